// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs external loader, one shared RAM port.
// Ports: clk/rst, iCpu*/oCpu*/oStall (CPU side), iBus*/oBus* (loader side),
//   oMem*/iMemQ (block RAM, 1-cycle read), oConflictCnt (contention cycles).
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        iCpuRead,
  input  logic        iCpuWrite,
  input  logic [15:0] iCpuAddr,
  input  logic [15:0] iCpuWData,
  output logic [15:0] oCpuRData,
  output logic        oCpuValid,
  output logic        oStall,
  input  logic        iBusReq,
  input  logic        iBusWe,
  input  logic [15:0] iBusAddr,
  input  logic [15:0] iBusWData,
  output logic        oBusGnt,
  output logic [15:0] oBusRData,
  output logic        oBusValid,
  output logic [15:0] oMemAddr,
  output logic [15:0] oMemWData,
  output logic        oMemRden,
  output logic        oMemWren,
  input  logic [15:0] iMemQ,
  output logic [15:0] oConflictCnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic CPU = 1'b0;
  localparam logic BUS = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic cpu_req;
  logic cpu_win;
  logic bus_win;

  assign cpu_req = iCpuRead | iCpuWrite;
  // On contention the side not served last time wins.
  assign cpu_win = cpu_req & (~iBusReq | (last_q == BUS));
  assign bus_win = iBusReq & ~cpu_win;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    oCpuRData = '0;
    oCpuValid = 1'b0;
    oStall    = 1'b0;
    oBusGnt   = 1'b0;
    oBusRData = '0;
    oBusValid = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    oMemRden  = 1'b0;
    oMemWren  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && iBusReq && (cnt_q != 16'hFFFF))
          cnt_d = cnt_q + 16'd1;
        if (cpu_win) begin
          oMemAddr  = iCpuAddr;
          oMemWData = iCpuWData;
          oMemWren  = iCpuWrite;
          oMemRden  = ~iCpuWrite;
          last_d    = CPU;
          if (!iCpuWrite) begin
            state_d = RD_WAIT;
            owner_d = CPU;
          end
        end else if (bus_win) begin
          oMemAddr  = iBusAddr;
          oMemWData = iBusWData;
          oMemWren  = iBusWe;
          oMemRden  = ~iBusWe;
          oBusGnt   = 1'b1;
          last_d    = BUS;
          if (!iBusWe) begin
            state_d = RD_WAIT;
            owner_d = BUS;
          end
        end
        // Only a winning CPU store completes without a stall.
        oStall = cpu_req & ~(cpu_win & iCpuWrite);
      end
      RD_WAIT: begin
        state_d = IDLE;
        if (owner_q == CPU) begin
          oCpuValid = 1'b1;
          oCpuRData = iMemQ;
        end else begin
          oBusValid = 1'b1;
          oBusRData = iMemQ;
        end
        oStall = cpu_req & (owner_q != CPU);
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output, which also aborts a pending read.
    if (rst) begin
      oCpuRData = '0;
      oCpuValid = 1'b0;
      oStall    = 1'b0;
      oBusGnt   = 1'b0;
      oBusRData = '0;
      oBusValid = 1'b0;
      oMemAddr  = '0;
      oMemWData = '0;
      oMemRden  = 1'b0;
      oMemWren  = 1'b0;
    end
  end

  assign oConflictCnt = rst ? 16'h0000 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= CPU;
      last_q  <= BUS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a 1-cycle RAM model and a
// scoreboard queue of expected read returns.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iCpuRead = 1'b0;
  logic        iCpuWrite = 1'b0;
  logic [15:0] iCpuAddr = '0;
  logic [15:0] iCpuWData = '0;
  logic [15:0] oCpuRData;
  logic        oCpuValid;
  logic        oStall;
  logic        iBusReq = 1'b0;
  logic        iBusWe = 1'b0;
  logic [15:0] iBusAddr = '0;
  logic [15:0] iBusWData = '0;
  logic        oBusGnt;
  logic [15:0] oBusRData;
  logic        oBusValid;
  logic [15:0] oMemAddr;
  logic [15:0] oMemWData;
  logic        oMemRden;
  logic        oMemWren;
  logic [15:0] iMemQ;
  logic [15:0] oConflictCnt;

  typedef struct packed {
    logic        bus;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] ram [0:65535];
  logic [15:0] ram_q = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oMemWren) ram[oMemAddr] <= oMemWData;
    if (oMemRden) ram_q <= ram[oMemAddr];
  end
  assign iMemQ = ram_q;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .iCpuRead(iCpuRead), .iCpuWrite(iCpuWrite),
    .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
    .oCpuRData(oCpuRData), .oCpuValid(oCpuValid), .oStall(oStall),
    .iBusReq(iBusReq), .iBusWe(iBusWe),
    .iBusAddr(iBusAddr), .iBusWData(iBusWData),
    .oBusGnt(oBusGnt), .oBusRData(oBusRData), .oBusValid(oBusValid),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .oMemRden(oMemRden), .oMemWren(oMemWren),
    .iMemQ(iMemQ), .oConflictCnt(oConflictCnt)
  );

  task automatic drive_idle();
    iCpuRead  = 1'b0;
    iCpuWrite = 1'b0;
    iBusReq   = 1'b0;
    iBusWe    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    iCpuRead = 1'b1;
    iBusReq = 1'b1;
    iBusWe = 1'b1;
    #2;
    checks++;
    if ({oStall, oMemRden, oMemWren, oBusGnt} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl got %b want 0000",
               {oStall, oMemRden, oMemWren, oBusGnt});
    end
    checks++;
    if (oMemAddr !== 16'h0000) begin
      errors++;
      $display("FAIL rst_addr got %h want 0000", oMemAddr);
    end
    @(negedge clk);
    #2;
    checks++;
    if (oConflictCnt !== 16'h0000 || oCpuValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_cnt got %h/%b want 0000/0",
               oConflictCnt, oCpuValid);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cpu_load();
    exp_t e;
    @(negedge clk);
    iBusReq = 1'b1;
    iBusWe = 1'b1;
    iBusAddr = 16'h0010;
    iBusWData = 16'hBEEF;
    #2;
    checks++;
    if (oBusGnt !== 1'b1 || oMemWren !== 1'b1) begin
      errors++;
      $display("FAIL preload got gnt=%b wren=%b want 1/1",
               oBusGnt, oMemWren);
    end
    @(negedge clk);
    drive_idle();
    iCpuRead = 1'b1;
    iCpuAddr = 16'h0010;
    #2;
    checks++;
    if ({oMemRden, oStall} !== 2'b11 || oMemAddr !== 16'h0010) begin
      errors++;
      $display("FAIL ld_issue got rden/stall=%b addr=%h want 11/0010",
               {oMemRden, oStall}, oMemAddr);
    end
    sb.push_back('{bus: 1'b0, data: 16'hBEEF});
    @(negedge clk);
    #2;
    checks++;
    if (oStall !== 1'b0) begin
      errors++;
      $display("FAIL ld_stall got %b want 0", oStall);
    end
    checks++;
    if (oCpuValid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL ld_valid got %b want 1", oCpuValid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (e.bus !== 1'b0 || oCpuRData !== e.data) begin
        errors++;
        $display("FAIL ld_data got %h want %h", oCpuRData, e.data);
      end
    end
    drive_idle();
  endtask

  task automatic test_cpu_store();
    exp_t e;
    @(negedge clk);
    iCpuWrite = 1'b1;
    iCpuAddr = 16'h0020;
    iCpuWData = 16'h1234;
    #2;
    checks++;
    if ({oMemWren, oStall} !== 2'b10 || oMemAddr !== 16'h0020
        || oMemWData !== 16'h1234) begin
      errors++;
      $display("FAIL st_issue got wren/stall=%b addr=%h data=%h want 10/0020/1234",
               {oMemWren, oStall}, oMemAddr, oMemWData);
    end
    @(negedge clk);
    drive_idle();
    iCpuRead = 1'b1;
    iCpuAddr = 16'h0020;
    sb.push_back('{bus: 1'b0, data: 16'h1234});
    @(negedge clk);
    #2;
    checks++;
    if (oCpuValid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL st_rb_valid got %b want 1", oCpuValid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (oCpuRData !== e.data) begin
        errors++;
        $display("FAIL st_rb_data got %h want %h", oCpuRData, e.data);
      end
    end
    drive_idle();
  endtask

  task automatic test_contention();
    exp_t e;
    do_reset();
    iCpuRead = 1'b1;
    iCpuAddr = 16'h0010;
    iBusReq = 1'b1;
    iBusWe = 1'b1;
    iBusAddr = 16'h0030;
    iBusWData = 16'h5555;
    #2;
    checks++;
    if ({oMemRden, oBusGnt, oStall} !== 3'b101) begin
      errors++;
      $display("FAIL ct_c0 got rden/gnt/stall=%b want 101",
               {oMemRden, oBusGnt, oStall});
    end
    sb.push_back('{bus: 1'b0, data: 16'hBEEF});
    @(negedge clk);
    #2;
    checks++;
    if ({oBusGnt, oMemRden, oMemWren} !== 3'b000
        || oConflictCnt !== 16'd1) begin
      errors++;
      $display("FAIL ct_c1 got gnt/rd/wr=%b cnt=%0d want 000/1",
               {oBusGnt, oMemRden, oMemWren}, oConflictCnt);
    end
    checks++;
    if (oCpuValid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL ct_valid got %b want 1", oCpuValid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (oCpuRData !== e.data) begin
        errors++;
        $display("FAIL ct_data got %h want %h", oCpuRData, e.data);
      end
    end
    @(negedge clk);
    iCpuRead = 1'b0;
    #2;
    checks++;
    if ({oBusGnt, oMemWren} !== 2'b11 || oMemAddr !== 16'h0030
        || oConflictCnt !== 16'd1) begin
      errors++;
      $display("FAIL ct_c2 got gnt/wr=%b addr=%h cnt=%0d want 11/0030/1",
               {oBusGnt, oMemWren}, oMemAddr, oConflictCnt);
    end
    @(negedge clk);
    iBusWe = 1'b0;
    #2;
    checks++;
    if ({oBusGnt, oMemRden} !== 2'b11) begin
      errors++;
      $display("FAIL bus_rd_gnt got %b want 11", {oBusGnt, oMemRden});
    end
    sb.push_back('{bus: 1'b1, data: 16'h5555});
    @(negedge clk);
    drive_idle();
    #2;
    checks++;
    if (oBusValid !== 1'b1 || oCpuValid !== 1'b0 || sb.size() == 0) begin
      errors++;
      $display("FAIL bus_rd_valid got %b/%b want 1/0", oBusValid, oCpuValid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (e.bus !== 1'b1 || oBusRData !== e.data || oCpuRData !== 16'h0) begin
        errors++;
        $display("FAIL bus_rd_data got %h/%h want %h/0000",
                 oBusRData, oCpuRData, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] cpu_k = '0;
    logic [15:0] bus_k = '0;
    logic        want_cpu = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      iCpuWrite = 1'b1;
      iCpuAddr = 16'h0100 + cpu_k;
      iCpuWData = 16'hC000 + cpu_k;
      iBusReq = 1'b1;
      iBusWe = 1'b1;
      iBusAddr = 16'h0200 + bus_k;
      iBusWData = 16'hB000 + bus_k;
      #2;
      checks++;
      if (want_cpu) begin
        if ({oStall, oBusGnt, oMemWren} !== 3'b001
            || oMemAddr !== 16'h0100 + cpu_k) begin
          errors++;
          $display("FAIL b2b_cpu%0d got st/gnt/wr=%b addr=%h want 001/%h",
                   i, {oStall, oBusGnt, oMemWren}, oMemAddr,
                   16'h0100 + cpu_k);
        end
        cpu_k++;
      end else begin
        if ({oStall, oBusGnt, oMemWren} !== 3'b111
            || oMemAddr !== 16'h0200 + bus_k) begin
          errors++;
          $display("FAIL b2b_bus%0d got st/gnt/wr=%b addr=%h want 111/%h",
                   i, {oStall, oBusGnt, oMemWren}, oMemAddr,
                   16'h0200 + bus_k);
        end
        bus_k++;
      end
      want_cpu = ~want_cpu;
    end
    @(negedge clk);
    drive_idle();
    #2;
    checks++;
    if (oConflictCnt !== 16'd8) begin
      errors++;
      $display("FAIL b2b_cnt got %0d want 8", oConflictCnt);
    end
    iCpuRead = 1'b1;
    iCpuAddr = 16'h0102;
    sb.push_back('{bus: 1'b0, data: 16'hC002});
    @(negedge clk);
    #2;
    checks++;
    if (oCpuValid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL b2b_rb_valid got %b want 1", oCpuValid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (oCpuRData !== e.data) begin
        errors++;
        $display("FAIL b2b_rb_data got %h want %h", oCpuRData, e.data);
      end
    end
    @(negedge clk);
    drive_idle();
    iBusReq = 1'b1;
    iBusAddr = 16'h0203;
    sb.push_back('{bus: 1'b1, data: 16'hB003});
    @(negedge clk);
    drive_idle();
    #2;
    checks++;
    if (oBusValid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL b2b_bus_rb_valid got %b want 1", oBusValid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (oBusRData !== e.data) begin
        errors++;
        $display("FAIL b2b_bus_rb_data got %h want %h", oBusRData, e.data);
      end
    end
  endtask

  task automatic test_reset_rdwait();
    @(negedge clk);
    drive_idle();
    iBusReq = 1'b1;
    iBusAddr = 16'h0030;
    #2;
    checks++;
    if ({oBusGnt, oMemRden} !== 2'b11) begin
      errors++;
      $display("FAIL rr_gnt got %b want 11", {oBusGnt, oMemRden});
    end
    @(negedge clk);
    rst = 1'b1;
    iBusReq = 1'b0;
    #2;
    checks++;
    if (oBusValid !== 1'b0 || oBusRData !== 16'h0) begin
      errors++;
      $display("FAIL rr_in_rst got %b/%h want 0/0000", oBusValid, oBusRData);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if ({oCpuValid, oBusValid, oStall, oBusGnt, oMemRden, oMemWren} !== 6'b0
        || {oCpuRData, oBusRData, oMemAddr, oConflictCnt} !== 64'h0) begin
      errors++;
      $display("FAIL rr_after got ctl=%b data=%h want 0/0",
               {oCpuValid, oBusValid, oStall, oBusGnt, oMemRden, oMemWren},
               {oCpuRData, oBusRData, oMemAddr, oConflictCnt});
    end
    @(negedge clk);
    iCpuWrite = 1'b1;
    iCpuAddr = 16'h0040;
    iCpuWData = 16'h0777;
    #2;
    checks++;
    if ({oMemWren, oStall} !== 2'b10) begin
      errors++;
      $display("FAIL rr_idle_store got %b want 10", {oMemWren, oStall});
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    iCpuWrite = 1'b1;
    iCpuAddr = 16'h0050;
    iBusReq = 1'b1;
    iBusWe = 1'b1;
    iBusAddr = 16'h0060;
    repeat (65540) @(negedge clk);
    #2;
    checks++;
    if (oConflictCnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_cnt got %h want ffff", oConflictCnt);
    end
    @(negedge clk);
    #2;
    checks++;
    if (oConflictCnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got %h want ffff", oConflictCnt);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_contention();
    test_back_to_back();
    test_reset_rdwait();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with port names `clk` and `rst`.
REQ-002 The block SHALL expose the following ports, one per line:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `iCpuRead`  in  1  CPU MEM-stage load request.
- `iCpuWrite`  in  1  CPU MEM-stage store request.
- `iCpuAddr`  in  16  CPU address.
- `iCpuWData`  in  16  CPU store data.
- `oCpuRData`  out  16  CPU load data; meaningful only while `oCpuValid` is high.
- `oCpuValid`  out  1  CPU load data returned this cycle.
- `oStall`  out  1  CPU must hold its request and freeze fetch/decode.
- `iBusReq`  in  1  external loader (weight/DMA) request.
- `iBusWe`  in  1  loader write (1) / read (0).
- `iBusAddr`  in  16  loader address.
- `iBusWData`  in  16  loader write data.
- `oBusGnt`  out  1  loader request accepted this cycle.
- `oBusRData`  out  16  loader read data; meaningful only while `oBusValid` is high.
- `oBusValid`  out  1  loader read data returned this cycle.
- `oMemAddr`  out  16  block RAM address.
- `oMemWData`  out  16  block RAM write data.
- `oMemRden`  out  1  block RAM read enable.
- `oMemWren`  out  1  block RAM write enable.
- `iMemQ`  in  16  block RAM read data, valid one cycle after `oMemRden`.
- `oConflictCnt`  out  16  saturating count of contention cycles.

Function
REQ-003 The block SHALL define the CPU request as `cpu_req = iCpuRead | iCpuWrite`; when both are high, the request SHALL be treated as a write.
REQ-004 The block SHALL implement a two-state FSM, with states IDLE and RD_WAIT, and a registered owner bit (CPU or BUS).
REQ-005 In IDLE, the winner SHALL be selected as follows:
- a sole requester wins;
- if `cpu_req` and `iBusReq` are both high, the requester not granted most recently (`lastGnt`) wins.
REQ-006 In IDLE with a winner, the block SHALL drive `oMemAddr`/`oMemWData` from the winner combinationally, with `oMemWren` = winner write and `oMemRden` = winner read.
REQ-007 A winning write SHALL complete in the same cycle, the FSM SHALL stay in IDLE, and `lastGnt` SHALL update to the winner.
REQ-008 A winning read SHALL move the FSM to RD_WAIT with owner = winner, and `lastGnt` SHALL update to the winner.
REQ-009 In RD_WAIT, the block SHALL route `iMemQ` to the owner's RData and pulse the owner's Valid for exactly one cycle.
REQ-010 In RD_WAIT, `oMemRden`/`oMemWren` SHALL be 0 and no request SHALL be accepted; the FSM SHALL then return to IDLE.
REQ-011 `oBusGnt` SHALL be high only in an IDLE cycle in which BUS wins, for one cycle per accepted transaction.
REQ-012 The loader SHALL hold `iBusReq`, `iBusWe`, `iBusAddr` and `iBusWData` until `oBusGnt` is high.
REQ-013 `oStall` SHALL equal `cpu_req` AND NOT(IDLE, CPU wins, write) AND NOT(RD_WAIT, owner = CPU); it SHALL be combinational.
REQ-014 The CPU SHALL hold its request while `oStall` is high.
REQ-015 A CPU load SHALL take 2 cycles (stall, then valid); a CPU store SHALL take 1 cycle if uncontested.
REQ-016 A CPU load issued in IDLE SHALL see `oStall` high in the issue cycle and low in RD_WAIT, in which `oCpuValid` = 1.
REQ-017 Fairness: neither requester SHALL wait for more than one complete transaction of the other (at most 2 cycles).
REQ-018 While idle, or when not the owner, `oCpuRData`/`oBusRData` SHALL be 0 and both Valids SHALL be 0.
REQ-019 `oConflictCnt` SHALL increment by 1 in each IDLE cycle in which `cpu_req` and `iBusReq` are both high, and SHALL saturate at 16'hFFFF.
REQ-020 Addresses and data SHALL pass through unmodified at full 16-bit width; truncation to the RAM depth is the RAM wrapper's concern.

Reset
REQ-021 While `rst` is high at a rising edge, the block SHALL set:
- FSM = IDLE;
- `lastGnt` = BUS, so the CPU wins the first contention;
- owner = CPU;
- `oConflictCnt` = 0.
REQ-022 While `rst` is high, all outputs SHALL be 0, including `oStall`, `oMemRden` and `oMemWren`.
REQ-023 Reset asserted in RD_WAIT SHALL abort the read: no Valid pulse SHALL appear, and the next cycle SHALL be IDLE.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- CPU-only load at addr 0x0010, RAM holds 0xBEEF -> cycle 0: `oMemRden`=1, `oStall`=1; cycle 1: `oCpuValid`=1, `oCpuRData`=0xBEEF, `oStall`=0.
- CPU store 0x1234 to 0x0020 with bus idle -> same cycle: `oMemWren`=1, `oMemAddr`=0x0020, `oStall`=0; a later load returns 0x1234.
- First contention after reset, CPU load plus bus write -> CPU wins, then the bus gets `oBusGnt` in the cycle after RD_WAIT, and `oConflictCnt`=1 (2 if still contending).
- CPU and bus both issuing back-to-back continuous writes -> grants alternate CPU, BUS, CPU, BUS, and neither starves.
- Reset pulse during RD_WAIT of a bus read -> `oBusValid` never asserts, and all outputs are 0 on the cycle after reset.
- Force 65,540 contention cycles -> `oConflictCnt` holds at 0xFFFF.
